async_reg_bank: RTL and testbench

ASYNC_REG_BANK -- requirements
Module: async_reg_bank

---
 rtl/async_reg_pkg.sv | 26 ++
 rtl/async_reg_chan.sv | 93 +++++++++
 rtl/async_reg_bank.sv | 42 ++++
 tb/tb_async_reg_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/async_reg_pkg.sv
// Shared definitions for the async register bank: capture-edge encodings,
// synchroniser depth limit and the capture-event decode.
package async_reg_pkg;

    localparam int SYNC_STAGES_MAX = 3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_e;

    // prev is the delayed strobe, cur the synchronised strobe.
    function automatic logic capture_event(input edge_e mode, input logic prev, input logic cur);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = ~prev & cur;
            EDGE_FALL: hit = prev & ~cur;
            EDGE_BOTH: hit = prev ^ cur;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/async_reg_chan.sv
// One register channel: strobe/data synchroniser, edge-detected capture and
// sticky set/clear overrides on the combinational output.
module async_reg_chan
    import async_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 0,
    parameter edge_e            EDGE        = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s,
    input  logic             r,
    input  logic             c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             wr_pulse
);

    logic             c_s;
    logic [WIDTH-1:0] d_s;

    // Data rides an equal-depth pipeline so it stays aligned with its strobe.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign c_s = c;
            assign d_s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] c_sync_q;
            logic [SYNC_STAGES-1:0] c_sync_d;
            logic [WIDTH-1:0]       d_sync_q [SYNC_STAGES];
            logic [WIDTH-1:0]       d_sync_d [SYNC_STAGES];

            always_comb begin
                c_sync_d    = '0;
                d_sync_d    = '{default: '0};
                c_sync_d[0] = c;
                d_sync_d[0] = d;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    c_sync_d[i] = c_sync_q[i-1];
                    d_sync_d[i] = d_sync_q[i-1];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    c_sync_q <= '0;
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        d_sync_q[i] <= '0;
                    end
                end else begin
                    c_sync_q <= c_sync_d;
                    d_sync_q <= d_sync_d;
                end
            end

            assign c_s = c_sync_q[SYNC_STAGES-1];
            assign d_s = d_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] val_q, val_d;
    logic             c_dly_q, c_dly_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic             capture;
    logic             override;

    // val reloads q every cycle, which makes a set/clear stick after release.
    always_comb begin
        override   = r | s;
        capture    = capture_event(EDGE, c_dly_q, c_s);
        q          = r ? '0 : (s ? '1 : val_q);
        val_d      = (capture && !override) ? d_s : q;
        wr_pulse_d = capture && !override;
        c_dly_d    = c_s;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            val_q      <= RESET_VAL;
            c_dly_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            val_q      <= val_d;
            c_dly_q    <= c_dly_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign wr_pulse = wr_pulse_q;

endmodule

// File: rtl/async_reg_bank.sv
// Bank of independent register channels written by strobes from a foreign
// clock domain; ports are packed channel-major.
module async_reg_bank
    import async_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter int               SYNC_STAGES = 0,
    parameter edge_e            EDGE        = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       s,
    input  logic [CHANNELS-1:0]       r,
    input  logic [CHANNELS-1:0]       c,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       wr_pulse
);

    generate
        for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
            async_reg_chan #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE        (EDGE),
                .RESET_VAL   (RESET_VAL)
            ) u_chan (
                .clock    (clock),
                .reset    (reset),
                .s        (s[n]),
                .r        (r[n]),
                .c        (c[n]),
                .d        (d[n*WIDTH +: WIDTH]),
                .q        (q[n*WIDTH +: WIDTH]),
                .wr_pulse (wr_pulse[n])
            );
        end
    endgenerate

endmodule

// File: tb/tb_async_reg_bank.sv
// Directed bench for async_reg_bank: a vector table on the default build plus
// hand sequences for synchroniser latency, both-edge capture and reset.
module tb_async_reg_bank;
    import async_reg_pkg::*;

    logic        clk;
    logic        rst   [4];
    logic [3:0]  s_v   [4];
    logic [3:0]  r_v   [4];
    logic [3:0]  c_v   [4];
    logic [31:0] d_v   [4];
    logic [31:0] q_v   [4];
    logic [3:0]  wr_v  [4];

    int tests_run = 0;
    int tests_failed = 0;

    // 0: defaults, 1: SYNC_STAGES=2, 2: EDGE_BOTH, 3: SYNC_STAGES=1 RESET_VAL=A5
    async_reg_bank u_def (
        .clock(clk), .reset(rst[0]), .s(s_v[0]), .r(r_v[0]), .c(c_v[0]),
        .d(d_v[0]), .q(q_v[0]), .wr_pulse(wr_v[0]));

    async_reg_bank #(.SYNC_STAGES(2)) u_s2 (
        .clock(clk), .reset(rst[1]), .s(s_v[1]), .r(r_v[1]), .c(c_v[1]),
        .d(d_v[1]), .q(q_v[1]), .wr_pulse(wr_v[1]));

    async_reg_bank #(.EDGE(EDGE_BOTH)) u_both (
        .clock(clk), .reset(rst[2]), .s(s_v[2]), .r(r_v[2]), .c(c_v[2]),
        .d(d_v[2]), .q(q_v[2]), .wr_pulse(wr_v[2]));

    async_reg_bank #(.SYNC_STAGES(1), .RESET_VAL(8'hA5)) u_rv (
        .clock(clk), .reset(rst[3]), .s(s_v[3]), .r(r_v[3]), .c(c_v[3]),
        .d(d_v[3]), .q(q_v[3]), .wr_pulse(wr_v[3]));

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  s;
        logic [3:0]  r;
        logic [3:0]  c;
        logic [31:0] d;
        logic [31:0] exp_q;
        logic [3:0]  exp_wr;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits up to 8 clocks for wr_pulse bit; returns cycle count or 99 on timeout.
    task automatic wait_wr(input int inst, input int bit_i, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 99;
        for (int k = 1; k <= 8; k++) begin
            if (!done) begin
                @(posedge clk);
                #1;
                if (wr_v[inst][bit_i]) begin
                    cyc  = k;
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        logic any_wr;

        // fields: s, r, c, d, exp_q, exp_wr
        vecs[0]  = '{4'h0, 4'h0, 4'h1, 32'h0000005A, 32'h0000005A, 4'h1};
        vecs[1]  = '{4'h0, 4'h0, 4'h1, 32'hFFFFFFFF, 32'h0000005A, 4'h0};
        vecs[2]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 32'h0000005A, 4'h0};
        vecs[3]  = '{4'h0, 4'h0, 4'h4, 32'h00110000, 32'h0011005A, 4'h4};
        vecs[4]  = '{4'h0, 4'h4, 4'h0, 32'h00000000, 32'h0000005A, 4'h0};
        vecs[5]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 32'h0000005A, 4'h0};
        vecs[6]  = '{4'h4, 4'h0, 4'h0, 32'h00000000, 32'h00FF005A, 4'h0};
        vecs[7]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 32'h00FF005A, 4'h0};
        vecs[8]  = '{4'h0, 4'h8, 4'h8, 32'h77000000, 32'h00FF005A, 4'h0};
        vecs[9]  = '{4'h0, 4'h0, 4'h8, 32'h77000000, 32'h00FF005A, 4'h0};
        vecs[10] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 32'h00FF005A, 4'h0};
        vecs[11] = '{4'h0, 4'h0, 4'hF, 32'h44332211, 32'h44332211, 4'hF};
        vecs[12] = '{4'h0, 4'h0, 4'hF, 32'h00000000, 32'h44332211, 4'h0};
        vecs[13] = '{4'h3, 4'h1, 4'h0, 32'h00000000, 32'h4433FF00, 4'h0};
        vecs[14] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 32'h4433FF00, 4'h0};

        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            s_v[i] = '0;
            r_v[i] = '0;
            c_v[i] = '0;
            d_v[i] = '0;
        end
        // Strobe held high through reset on the two-stage build.
        c_v[1] = 4'h1;
        d_v[1] = 32'h00000099;
        repeat (3) @(posedge clk);

        // Default build: reset state then the vector table
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        check("def_reset_q", q_v[0], 32'h0);
        check("def_reset_wr", {28'h0, wr_v[0]}, 32'h0);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            s_v[0] = vecs[i].s;
            r_v[0] = vecs[i].r;
            c_v[0] = vecs[i].c;
            d_v[0] = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q", i), q_v[0], vecs[i].exp_q);
            check($sformatf("vec%0d_wr", i), {28'h0, wr_v[0]}, {28'h0, vecs[i].exp_wr});
        end

        // Two-stage build: c held through reset counts as a rise 3 clocks after release
        @(negedge clk);
        rst[1] = 1'b0;
        wait_wr(1, 0, cyc);
        check("s2_held_latency", cyc, 3);
        check("s2_held_q", q_v[1], 32'h00000099);
        @(negedge clk);
        c_v[1] = 4'h3;
        d_v[1] = 32'h00003C99;
        wait_wr(1, 1, cyc);
        check("s2_c1_latency", cyc, 3);
        check("s2_c1_q", q_v[1], 32'h00003C99);
        check("s2_c1_wr", {28'h0, wr_v[1]}, 32'h2);

        // Both-edge build: rise then fall, each captures
        @(negedge clk);
        rst[2] = 1'b0;
        pulses = 0;
        @(negedge clk);
        c_v[2] = 4'h1;
        d_v[2] = 32'h00000001;
        @(posedge clk);
        #1;
        if (wr_v[2][0]) pulses++;
        check("both_rise_q", q_v[2], 32'h00000001);
        @(negedge clk);
        c_v[2] = 4'h0;
        d_v[2] = 32'h00000002;
        @(posedge clk);
        #1;
        if (wr_v[2][0]) pulses++;
        check("both_fall_q", q_v[2], 32'h00000002);
        @(negedge clk);
        @(posedge clk);
        #1;
        if (wr_v[2][0]) pulses++;
        check("both_pulses", pulses, 2);
        check("both_idle_wr", {28'h0, wr_v[2]}, 32'h0);

        // RESET_VAL build: reset mid-synchronisation drops the capture
        @(negedge clk);
        rst[3] = 1'b0;
        #1;
        check("rv_reset_q", q_v[3], 32'hA5A5A5A5);
        @(negedge clk);
        c_v[3] = 4'hF;
        d_v[3] = 32'h12345678;
        @(posedge clk);
        #1;
        check("rv_inflight_wr", {28'h0, wr_v[3]}, 32'h0);
        @(negedge clk);
        rst[3] = 1'b1;
        c_v[3] = 4'h0;
        r_v[3] = 4'h1;
        #1;
        check("rv_in_reset_q", q_v[3], 32'hA5A5A500);
        check("rv_in_reset_wr", {28'h0, wr_v[3]}, 32'h0);
        @(negedge clk);
        r_v[3] = 4'h0;
        @(negedge clk);
        rst[3] = 1'b0;
        any_wr = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (wr_v[3] != 4'h0) any_wr = 1'b1;
        end
        check("rv_after_wr", {31'h0, any_wr}, 32'h0);
        check("rv_after_q", q_v[3], 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
